// File: rtl/sqrt_req_scheduler.sv
// Round-robin scheduler sharing one square-root unit between NREQ requesters.
// One operation in flight; a watchdog turns a hung unit into an error response.
module sqrt_req_scheduler #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned IDW     = 2,
    parameter int unsigned TIMEOUT = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NREQ-1:0]      req_valid_i,
    input  logic [32*NREQ-1:0]   req_data_i,
    output logic [NREQ-1:0]      req_ready_o,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [IDW-1:0]       rsp_id_o,
    output logic [15:0]          rsp_data_o,
    output logic                 rsp_err_o,
    output logic                 busy_o,
    output logic                 sq_start_o,
    output logic [31:0]          sq_inp_o,
    input  logic [15:0]          sq_result_i,
    input  logic                 sq_stop_i
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StLaunch, StWait, StDone} state_e;

    state_e          state_q;
    logic [IDW-1:0]  last_grant_q;
    logic [IDW-1:0]  rsp_id_q;
    logic [31:0]     sq_inp_q;
    logic [15:0]     rsp_data_q;
    logic            rsp_err_q;
    logic            rsp_valid_q;
    logic            sq_start_q;
    logic            busy_q;
    logic [CntW-1:0] cnt_q;

    logic [IDW-1:0]  grant_idx;
    logic [IDW-1:0]  cand;
    logic            grant_found;
    logic [31:0]     grant_data;

    // Search starts just after the last grant and wraps around.
    always_comb begin
        grant_idx   = '0;
        grant_found = 1'b0;
        cand        = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = IDW'((32'(last_grant_q) + k) % NREQ);
            if (!grant_found && req_valid_i[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                grant_data = req_data_i[32*i +: 32];
            end
        end
    end

    assign req_ready_o = (rst_ni && state_q == StIdle && grant_found) ?
                         (NREQ'(1) << grant_idx) : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            last_grant_q <= IDW'(NREQ - 1);
            rsp_id_q     <= '0;
            sq_inp_q     <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            rsp_valid_q  <= 1'b0;
            sq_start_q   <= 1'b0;
            busy_q       <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sq_start_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (grant_found) begin
                        sq_inp_q     <= grant_data;
                        rsp_id_q     <= grant_idx;
                        last_grant_q <= grant_idx;
                        sq_start_q   <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= StLaunch;
                    end
                end
                StLaunch: begin
                    cnt_q   <= '0;
                    state_q <= StWait;
                end
                StWait: begin
                    cnt_q <= cnt_q + 1'b1;
                    // cnt_q == 0 marks the first WAIT cycle, where a stale stop is masked.
                    if (sq_stop_i && cnt_q != '0) begin
                        rsp_data_q  <= sq_result_i;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                        rsp_data_q  <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;
    assign busy_o      = busy_q;
    assign sq_start_o  = sq_start_q;
    assign sq_inp_o    = sq_inp_q;

endmodule

// File: tb/tb_sqrt_req_scheduler.sv
// Bench for sqrt_req_scheduler: behavioural sqrt unit, round-robin reference
// model and a response scoreboard, plus directed corner-case sequences.
module tb_sqrt_req_scheduler;

    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int TIMEOUT = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [32*NREQ-1:0] req_data = '0;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [IDW-1:0]    rsp_id;
    logic [15:0]       rsp_data;
    logic              rsp_err;
    logic              busy;
    logic              sq_start;
    logic [31:0]       sq_inp;
    logic [15:0]       sq_result = '0;
    logic              sq_stop = 1'b0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Unit behaviour controls.
    logic hang = 1'b0;
    logic lazy = 1'b0;

    sqrt_req_scheduler #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_id_o    (rsp_id),
        .rsp_data_o  (rsp_data),
        .rsp_err_o   (rsp_err),
        .busy_o      (busy),
        .sq_start_o  (sq_start),
        .sq_inp_o    (sq_inp),
        .sq_result_i (sq_result),
        .sq_stop_i   (sq_stop)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    function automatic logic [15:0] isqrt(input logic [31:0] x);
        longint r;
        longint t;
        r = 0;
        for (int b = 15; b >= 0; b--) begin
            t = r | (longint'(1) << b);
            if (t * t <= longint'(x)) r = t;
        end
        return 16'(r);
    endfunction

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    // Behavioural sqrt unit, updated on negedge to stay clear of the DUT edge.
    // Stop rises 18 cycles after the start cycle; lazy mode holds the stale stop
    // through the first WAIT cycle.
    logic [31:0] u_inp = '0;
    int          u_cnt = 0;
    int          u_drop = 0;
    always @(negedge clk) begin
        if (sq_start) begin
            u_inp  = sq_inp;
            u_cnt  = hang ? 0 : 18;
            u_drop = lazy ? 2 : 0;
            if (!lazy) sq_stop = 1'b0;
        end else begin
            if (u_drop != 0) begin
                u_drop--;
                if (u_drop == 0) sq_stop = 1'b0;
            end
            if (u_cnt != 0) begin
                if (u_cnt == 1) begin
                    sq_stop   = 1'b1;
                    sq_result = isqrt(u_inp);
                end
                u_cnt--;
            end
        end
    end

    typedef struct {
        int          id;
        logic [31:0] din;
        logic [15:0] data;
        logic        err;
        int          acc;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   m_last = NREQ - 1;
    int   m_acc = -100;
    logic rsp_prev = 1'b0;

    // Scoreboard monitor.
    always @(negedge clk) begin
        exp_t e;
        int   pick;
        if (!rst_n) begin
            exp_q.delete();
            m_last   = NREQ - 1;
            rsp_prev = 1'b0;
        end else begin
            if (|(req_valid & req_ready)) begin
                pick = rr_pick(req_valid, m_last);
                chk("grant_onehot", 32'(req_ready), 32'(1) << pick);
                m_last = pick;
                m_acc  = cyc;
                e.id   = pick;
                e.din  = req_data[32*pick +: 32];
                e.data = hang ? 16'h0 : isqrt(e.din);
                e.err  = hang;
                e.acc  = cyc;
                e.lat  = hang ? TIMEOUT + 2 : 20;
                exp_q.push_back(e);
            end
            if (sq_start) begin
                chk("sq_start_time", 32'(cyc), 32'(m_acc + 1));
                if (exp_q.size() > 0) chk("sq_inp", sq_inp, exp_q[0].din);
            end
            if (rsp_valid && !rsp_prev) begin
                if (exp_q.size() > 0) chk("latency", 32'(cyc - exp_q[0].acc), 32'(exp_q[0].lat));
                else chk("rsp_unexpected", 32'(exp_q.size()), 32'd1);
            end
            if (rsp_valid && rsp_ready && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rsp_id", 32'(rsp_id), 32'(e.id));
                chk("rsp_data", 32'(rsp_data), 32'(e.data));
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
            end
            rsp_prev = rsp_valid;
        end
    end

    task automatic wait_accept(input string name, output logic [NREQ-1:0] rdy, output int c);
        bit seen = 0;
        rdy = '0;
        c   = -1;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (|(req_valid & req_ready)) begin
                seen = 1;
                rdy  = req_ready;
                c    = cyc;
            end
        end
        if (!seen) fail_timeout(name);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(input string name);
        bit seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1;
        end
        if (!seen) fail_timeout(name);
    endtask

    typedef struct {
        int          idx;
        logic [31:0] din;
        logic [15:0] dout;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [NREQ-1:0] rdy;
        int              c;
        int              c_prev;
        logic [IDW-1:0]  h_id;
        logic [15:0]     h_data;
        logic            h_err;
        logic [NREQ-1:0] exp_fair[6];

        vecs[0] = '{idx: 0, din: 32'h0000_1000, dout: 16'h0040};
        vecs[1] = '{idx: 1, din: 32'h0000_0000, dout: 16'h0000};
        vecs[2] = '{idx: 2, din: 32'hFFFF_FFFF, dout: 16'hFFFF};
        vecs[3] = '{idx: 1, din: 32'h0001_0000, dout: 16'h0100};
        vecs[4] = '{idx: 3, din: 32'h0000_0400, dout: 16'h0020};
        exp_fair = '{4'b0001, 4'b0100, 4'b0001, 4'b0100, 4'b0001, 4'b0100};

        // Reset: outputs idle and no grant even with every request pending.
        req_valid = 4'b1111;
        #12;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sq_start", 32'(sq_start), 32'd0);
        chk("rst_sq_inp", sq_inp, 32'd0);
        req_valid = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single-requester vectors.
        foreach (vecs[n]) begin
            req_data[32*vecs[n].idx +: 32] = vecs[n].din;
            req_valid = NREQ'(1) << vecs[n].idx;
            wait_accept("vec_accept", rdy, c);
            chk("vec_ready", 32'(rdy), 32'(1) << vecs[n].idx);
            req_valid = '0;
            wait_rsp("vec_rsp");
            chk("vec_data", 32'(rsp_data), 32'(vecs[n].dout));
            chk("vec_id", 32'(rsp_id), 32'(vecs[n].idx));
            @(posedge clk);
            #1;
        end

        // All requesters pending; stale stop held into the first WAIT cycle.
        lazy = 1'b1;
        req_data = {32'h0000_4000, 32'h0000_2400, 32'h0000_1000, 32'h0000_0400};
        req_valid = 4'b1111;
        c_prev = -1;
        for (int i = 0; i < 4; i++) begin
            wait_accept("all_accept", rdy, c);
            chk("all_order", 32'(rdy), 32'(1) << i);
            if (i > 0) chk("all_spacing", 32'(c - c_prev), 32'd21);
            c_prev = c;
        end
        req_valid = '0;
        wait_rsp("all_rsp");
        chk("all_last_data", 32'(rsp_data), 32'h0080);
        @(posedge clk);
        #1;
        lazy = 1'b0;

        // Fairness between requesters 0 and 2.
        req_data = {32'h0, 32'h0000_0009, 32'h0, 32'h0001_0000};
        req_valid = 4'b0101;
        for (int i = 0; i < 6; i++) begin
            wait_accept("fair_accept", rdy, c);
            chk("fair_grant", 32'(rdy), 32'(exp_fair[i]));
        end
        req_valid = '0;
        wait_rsp("fair_rsp");
        @(posedge clk);
        #1;

        // Backpressure: response held, no grants while DONE.
        rsp_ready = 1'b0;
        req_data[32*1 +: 32] = 32'h0000_9000;
        req_valid = 4'b0010;
        wait_accept("bp_accept", rdy, c);
        req_valid = '0;
        wait_rsp("bp_rsp");
        h_id = rsp_id;
        h_data = rsp_data;
        h_err = rsp_err;
        chk("bp_data", 32'(h_data), 32'h00C0);
        @(posedge clk);
        #1;
        req_valid = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_stable", {13'(0), h_err, h_id, h_data}, {13'(0), rsp_err, rsp_id, rsp_data});
            chk("bp_no_grant", 32'(req_ready), 32'd0);
            chk("bp_busy", 32'(busy), 32'd1);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_idle_busy", 32'(busy), 32'd0);
        chk("bp_idle_grant", 32'(req_ready), 32'b0100);
        @(posedge clk);
        #1;
        req_valid = '0;
        wait_rsp("bp_next_rsp");
        @(posedge clk);
        #1;

        // Watchdog: unit never raises stop.
        hang = 1'b1;
        req_data[31:0] = 32'h0000_1000;
        req_valid = 4'b0001;
        wait_accept("wd_accept", rdy, c);
        req_valid = '0;
        wait_rsp("wd_rsp");
        chk("wd_err", 32'(rsp_err), 32'd1);
        chk("wd_data", 32'(rsp_data), 32'd0);
        chk("wd_time", 32'(cyc - c), 32'(TIMEOUT + 2));
        @(posedge clk);
        #1;
        hang = 1'b0;
        req_valid = 4'b0001;
        wait_accept("wd_next_accept", rdy, c);
        req_valid = '0;
        wait_rsp("wd_next_rsp");
        chk("wd_next_err", 32'(rsp_err), 32'd0);
        chk("wd_next_data", 32'(rsp_data), 32'h0040);
        @(posedge clk);
        #1;

        // Reset in the 8th WAIT cycle; last grant was 0 before reset.
        req_data[31:0] = 32'h0004_0000;
        req_valid = 4'b0001;
        wait_accept("rst_op_accept", rdy, c);
        req_valid = '0;
        repeat (8) @(posedge clk);
        #1;
        chk("mid_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        req_valid = 4'b1111;
        #1;
        chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_sq_start", 32'(sq_start), 32'd0);
        chk("mid_ready", 32'(req_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_accept("post_rst_accept", rdy, c);
        chk("post_rst_grant", 32'(rdy), 32'b0001);
        req_valid = '0;
        wait_rsp("post_rst_rsp");
        chk("post_rst_data", 32'(rsp_data), 32'h0200);
        chk("post_rst_latency", 32'(cyc - c), 32'd20);
        @(posedge clk);
        #1;
        repeat (3) @(posedge clk);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "global timeout");
    end

endmodule
